// File: rtl/urv_divide_pkg.sv
// Shared definitions for the iterative M-extension divider:
// funct3 encodings, FSM state type and an operand magnitude helper.
package urv_divide_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FIXUP,
        ST_DONE
    } state_t;

    // Magnitude of a signed operand; 0x80000000 stays 0x80000000,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(
        input logic [31:0] v,
        input logic        is_signed
    );
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/urv_divide_step.sv
// One restoring-division step on a {rem,quo} accumulator.
// Ports: acc (current {rem,quo}), divisor, acc_next (after one step).
module urv_div_step (
    input  logic [63:0] acc,
    input  logic [31:0] divisor,
    output logic [63:0] acc_next
);

    // The shifted remainder can reach 33 bits when the divisor is
    // above 2^31, so the trial subtract keeps an extra borrow bit.
    logic [32:0] rem_sh;
    logic [33:0] trial;

    assign rem_sh = acc[63:31];
    assign trial  = {1'b0, rem_sh} - {2'b00, divisor};

    always_comb begin
        acc_next = {acc[62:0], 1'b0};
        if (!trial[33]) begin
            acc_next = {trial[31:0], acc[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/urv_divide.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU.
// Ports: d_* operands from decode, x_stall_i/x_kill_i pipeline control,
// x_stall_req_o busy stall, w_valid_o/w_rd_o writeback result.
module urv_divide
    import urv_divide_pkg::*;
#(
    parameter bit g_fast_special = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        d_valid_i,
    input  logic        d_is_divide_i,
    input  logic [2:0]  d_fun_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    output logic        x_stall_req_o,
    output logic        w_valid_o,
    output logic [31:0] w_rd_o
);

    state_t state_q, state_d;

    logic [63:0] acc_q;
    logic [63:0] acc_nxt;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;
    logic        rem_sel_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [31:0] rd_q;

    logic        start;
    logic        is_signed;
    logic        zero_in;
    logic        ovf_in;
    logic        fast;
    logic [31:0] fast_rd;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        stall_req;

    assign start = (state_q == ST_IDLE) & d_valid_i & d_is_divide_i
                 & d_fun_i[2] & ~x_kill_i;

    assign is_signed = ~d_fun_i[0];
    assign zero_in   = (d_rs2_i == 32'h0);
    assign ovf_in    = is_signed & (d_rs1_i == 32'h8000_0000)
                     & (d_rs2_i == 32'hFFFF_FFFF);
    assign fast      = g_fast_special & (zero_in | ovf_in);

    always_comb begin
        fast_rd = d_fun_i[1] ? d_rs1_i : 32'hFFFF_FFFF;
        if (!zero_in) begin
            fast_rd = d_fun_i[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    urv_div_step u_step (
        .acc      (acc_q),
        .divisor  (dvs_q),
        .acc_next (acc_nxt)
    );

    assign quo_fix = neg_quo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stall_req = 1'b1;
                    state_d   = fast ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_req = 1'b1;
                if (x_kill_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 5'd31) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                stall_req = 1'b1;
                state_d   = x_kill_i ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (x_kill_i || !x_stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q     <= 64'h0;
            dvs_q     <= 32'h0;
            cnt_q     <= 5'd0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rem_sel_q <= d_fun_i[1];
                        // A zero divisor must yield all-ones whatever
                        // the signs, so it never negates the quotient.
                        neg_quo_q <= is_signed & ~zero_in
                                   & (d_rs1_i[31] ^ d_rs2_i[31]);
                        neg_rem_q <= is_signed & d_rs1_i[31];
                        acc_q     <= {32'h0, abs32(d_rs1_i, is_signed)};
                        dvs_q     <= abs32(d_rs2_i, is_signed);
                        cnt_q     <= 5'd0;
                        if (fast) begin
                            rd_q <= fast_rd;
                        end
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + 5'd1;
                end
                ST_FIXUP: begin
                    if (!x_kill_i) begin
                        rd_q <= rem_sel_q ? rem_fix : quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_stall_req_o = stall_req;
    assign w_valid_o     = (state_q == ST_DONE);
    assign w_rd_o        = rd_q;

endmodule

// File: tb/tb_urv_divide.sv
// Self-checking bench for urv_divide: fast and iterative special-case
// variants side by side against an arithmetic reference model.
module tb_urv_divide;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid;
    logic        d_is_div;
    logic [2:0]  d_fun;
    logic [31:0] d_rs1;
    logic [31:0] d_rs2;
    logic        stall;
    logic        kill;

    logic        stall_req [2];
    logic        w_valid   [2];
    logic [31:0] w_rd      [2];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    urv_divide #(.g_fast_special(1'b1)) dut_fast (
        .clk_i(clk), .rst_i(rst_n),
        .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
        .d_fun_i(d_fun), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2),
        .x_stall_i(stall), .x_kill_i(kill),
        .x_stall_req_o(stall_req[0]), .w_valid_o(w_valid[0]),
        .w_rd_o(w_rd[0])
    );

    urv_divide #(.g_fast_special(1'b0)) dut_slow (
        .clk_i(clk), .rst_i(rst_n),
        .d_valid_i(d_valid), .d_is_divide_i(d_is_div),
        .d_fun_i(d_fun), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2),
        .x_stall_i(stall), .x_kill_i(kill),
        .x_stall_req_o(stall_req[1]), .w_valid_o(w_valid[1]),
        .w_rd_o(w_rd[1])
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        sgn = ~f[0];
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return f[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'h0) ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference model: one pending op per DUT, with result and the
    // number of clock edges until it appears on the writeback port.
    bit          m_busy [2];
    bit          m_outv [2];
    int          m_left [2];
    logic [31:0] m_exp  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_outv[i] <= 1'b0;
                m_left[i] <= 0;
            end else if (m_busy[i]) begin
                if (kill) begin
                    m_busy[i] <= 1'b0;
                end else begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_outv[i] <= 1'b1;
                    end
                end
            end else if (m_outv[i]) begin
                if (kill || !stall) m_outv[i] <= 1'b0;
            end else if (d_valid && d_is_div && !kill) begin
                m_exp[i] <= ref_result(d_fun, d_rs1, d_rs2);
                if (i == 0 && is_special(d_fun, d_rs1, d_rs2)) begin
                    m_outv[i] <= 1'b1;
                end else begin
                    m_busy[i] <= 1'b1;
                    m_left[i] <= 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                check($sformatf("rst valid[%0d]", i), 32'(w_valid[i]), 32'h0);
                check($sformatf("rst rd[%0d]", i), w_rd[i], 32'h0);
                check($sformatf("rst stall[%0d]", i), 32'(stall_req[i]), 32'h0);
            end else begin
                check($sformatf("valid[%0d]", i), 32'(w_valid[i]),
                      32'(m_outv[i]));
                if (m_outv[i])
                    check($sformatf("rd[%0d]", i), w_rd[i], m_exp[i]);
                check($sformatf("stall_req[%0d]", i), 32'(stall_req[i]),
                      32'(m_busy[i] || (!m_outv[i] && d_valid &&
                                        d_is_div && !kill)));
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk); #1;
        d_valid = 1'b1; d_is_div = 1'b1; d_fun = f; d_rs1 = a; d_rs2 = b;
        @(posedge clk); #1;
        d_valid = 1'b0; d_is_div = 1'b0;
        d_rs1 = $urandom; d_rs2 = $urandom;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_v, input int lat_fast);
        int          lat [2];
        logic [31:0] rd  [2];
        lat[0] = 0; lat[1] = 0; rd[0] = '0; rd[1] = '0;
        issue(f, a, b);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (w_valid[i] && lat[i] == 0) begin
                    lat[i] = k;
                    rd[i]  = w_rd[i];
                end
            end
        end
        check({nm, " fast lat"}, 32'(lat[0]), 32'(lat_fast));
        check({nm, " fast rd"}, rd[0], exp_v);
        check({nm, " slow lat"}, 32'(lat[1]), 32'd34);
        check({nm, " slow rd"}, rd[1], exp_v);
    endtask

    initial begin
        int cnt [2];
        int seen;
        rst_n = 1'b1; d_valid = 1'b0; d_is_div = 1'b0; d_fun = 3'b100;
        d_rs1 = '0; d_rs2 = '0; stall = 1'b0; kill = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("div 100/7",  3'b100, 32'd100, 32'd7, 32'h0000_000E, 34);
        run_op("rem 100/7",  3'b110, 32'd100, 32'd7, 32'h0000_0002, 34);
        run_op("div -100/7", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);
        run_op("rem -100/7", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
        run_op("divu ff/2",  3'b101, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34);
        run_op("remu ff/2",  3'b111, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 34);
        run_op("div 5/0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem 5/0",    3'b110, 32'd5, 32'd0, 32'h0000_0005, 1);
        run_op("div -5/0",   3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem -5/0",   3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        run_op("divu 7/0",   3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("div min/1",  3'b100, 32'h8000_0000, 32'd1, 32'h8000_0000, 34);
        run_op("divu big",   3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, 34);
        run_op("remu big",   3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);

        // Kill at BUSY count 10.
        issue(3'b100, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        check("kill stall_req fast", 32'(stall_req[0]), 32'h0);
        check("kill stall_req slow", 32'(stall_req[1]), 32'h0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (w_valid[0] || w_valid[1]) seen++;
        end
        check("kill no valid", 32'(seen), 32'h0);
        run_op("div 9/3", 3'b100, 32'd9, 32'd3, 32'h3, 34);

        // Downstream stall held for 5 cycles in DONE.
        stall = 1'b1;
        cnt[0] = 0; cnt[1] = 0;
        issue(3'b100, 32'd100, 32'd7);
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (w_valid[i] && w_rd[i] == 32'h0000_000E) cnt[i]++;
        end
        @(posedge clk); #1 stall = 1'b0;
        check("stall hold fast", 32'(cnt[0]), 32'd5);
        check("stall hold slow", 32'(cnt[1]), 32'd5);
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of BUSY.
        issue(3'b100, 32'd12345, 32'd11);
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(w_valid[0] | w_valid[1]), 32'h0);
        check("async rst stall", 32'(stall_req[0] | stall_req[1]), 32'h0);
        check("async rst rd fast", w_rd[0], 32'h0);
        check("async rst rd slow", w_rd[1], 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op("remu 10/3", 3'b111, 32'd10, 32'd3, 32'h1, 34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
